// File: rtl/pe_row_skew_feeder_if.sv
// pe_row_skew_feeder_if: command, activation-input and skewed-output bundle
// for the PE-row skew feeder. The feeder takes the slave modport; the
// upstream/testbench side takes the master modport.
interface pe_row_skew_feeder_if #(
    parameter int INPUT_W = 8,
    parameter int DIM     = 4,
    parameter int LEN_W   = 8
);
    logic                     cfg_valid;
    logic                     cfg_ready;
    logic                     cfg_dataflow;
    logic [4:0]               cfg_shift;
    logic [LEN_W-1:0]         cfg_tile_len;
    logic [LEN_W-1:0]         cfg_num_tiles;
    logic                     in_valid;
    logic                     in_ready;
    logic [DIM*INPUT_W-1:0]   in_data;
    logic [DIM*INPUT_W-1:0]   out_a;
    logic [DIM-1:0]           out_valid;
    logic [DIM-1:0]           out_propagate;
    logic [DIM-1:0]           out_last;
    logic [DIM*3-1:0]         out_id;
    logic [DIM*5-1:0]         out_shift;
    logic [DIM-1:0]           out_dataflow;
    logic                     busy;
    logic                     done;

    modport master (
        output cfg_valid, cfg_dataflow, cfg_shift, cfg_tile_len, cfg_num_tiles,
        output in_valid, in_data,
        input  cfg_ready, in_ready,
        input  out_a, out_valid, out_propagate, out_last, out_id, out_shift,
        input  out_dataflow, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_dataflow, cfg_shift, cfg_tile_len, cfg_num_tiles,
        input  in_valid, in_data,
        output cfg_ready, in_ready,
        output out_a, out_valid, out_propagate, out_last, out_id, out_shift,
        output out_dataflow, busy, done
    );
endinterface

// File: rtl/pe_row_skew_feeder.sv
// pe_row_skew_feeder: upstream stage of a PE mesh row. Accepts one DIM-lane
// activation vector per beat and emits a diagonal stream (lane i delayed by
// i cycles relative to lane 0), with valid/propagate/last/id/shift/dataflow
// travelling alongside each lane's data. Sequences the tiles of one command
// (propagate toggles and id increments per tile), then drains the skew.
//
// Build option: define FEEDER_ZERO_BUBBLE_EN to force out_a to 0 in bubble
// slots. Without it the data registers only load on valid beats (they hold
// during bubbles to save toggle power); control fields always advance.
module pe_row_skew_feeder #(
    parameter int INPUT_W = 8,
    parameter int DIM     = 4,
    parameter int LEN_W   = 8
) (
    input logic                 clock,
    input logic                 reset_n,
    pe_row_skew_feeder_if.slave bus
);
    // Control word layout: {valid, propagate, last, id[2:0], shift[4:0], dataflow}
    localparam int CTL_W  = 12;
    localparam int DCNT_W = $clog2(DIM);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

    state_e              state_q, state_d;
    logic                df_q, df_d;
    logic [4:0]          shift_q, shift_d;
    logic [LEN_W-1:0]    tile_len_q, tile_len_d;
    logic [LEN_W-1:0]    num_tiles_q, num_tiles_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]    tile_cnt_q, tile_cnt_d;
    logic                prop_q, prop_d;
    logic [2:0]          id_q, id_d;
    logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;

    logic                accept;
    logic                last_beat;
    logic                last_tile;
    logic [CTL_W-1:0]    ctl_in;

    // Stored lengths are already clamped to >= 1, so "len - 1" never wraps.
    assign last_beat = (beat_cnt_q == tile_len_q - LEN_W'(1));
    assign last_tile = (tile_cnt_q == num_tiles_q - LEN_W'(1));

    // Next-state logic: command latch, beat/tile sequencing and skew drain.
    always_comb begin
        state_d     = state_q;
        df_d        = df_q;
        shift_d     = shift_q;
        tile_len_d  = tile_len_q;
        num_tiles_d = num_tiles_q;
        beat_cnt_d  = beat_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        prop_d      = prop_q;
        id_d        = id_q;
        drain_cnt_d = drain_cnt_q;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    df_d        = bus.cfg_dataflow;
                    shift_d     = bus.cfg_shift;
                    tile_len_d  = (bus.cfg_tile_len == '0) ? LEN_W'(1) : bus.cfg_tile_len;
                    num_tiles_d = (bus.cfg_num_tiles == '0) ? LEN_W'(1) : bus.cfg_num_tiles;
                    beat_cnt_d  = '0;
                    tile_cnt_d  = '0;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        prop_d     = ~prop_q;
                        id_d       = id_q + 3'd1;
                        tile_cnt_d = tile_cnt_q + LEN_W'(1);
                        if (last_tile) begin
                            state_d     = DRAIN;
                            drain_cnt_d = DCNT_W'(DIM - 1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat entering lane stage 0; bubbles carry valid=0 and last=0.
    assign ctl_in = {accept, prop_q, accept & last_beat, id_q, shift_q, df_q};

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.in_ready  = (state_q == STREAM);
    assign bus.busy      = (state_q != IDLE);
    // Drain count reaches 0 exactly when the last lane shows the final beat.
    assign bus.done      = (state_q == DRAIN) && (drain_cnt_q == '0);

    // FSM, latched command and tile-sequencing state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            df_q        <= 1'b0;
            shift_q     <= '0;
            tile_len_q  <= '0;
            num_tiles_q <= '0;
            beat_cnt_q  <= '0;
            tile_cnt_q  <= '0;
            prop_q      <= 1'b0;
            id_q        <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            df_q        <= df_d;
            shift_q     <= shift_d;
            tile_len_q  <= tile_len_d;
            num_tiles_q <= num_tiles_d;
            beat_cnt_q  <= beat_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            prop_q      <= prop_d;
            id_q        <= id_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        // Lane i uses i+1 stages so it lags lane 0 by i cycles.
        logic [INPUT_W-1:0] a_q [0:i];
        logic [CTL_W-1:0]   c_q [0:i];

        // Skew chain for lane i: control always shifts, data per build option.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int s = 0; s <= i; s++) begin
                    a_q[s] <= '0;
                    c_q[s] <= '0;
                end
            end else begin
                c_q[0] <= ctl_in;
`ifdef FEEDER_ZERO_BUBBLE_EN
                a_q[0] <= accept ? bus.in_data[i*INPUT_W +: INPUT_W] : '0;
`else
                if (accept) begin
                    a_q[0] <= bus.in_data[i*INPUT_W +: INPUT_W];
                end
`endif
                for (int s = 1; s <= i; s++) begin
                    c_q[s] <= c_q[s-1];
`ifdef FEEDER_ZERO_BUBBLE_EN
                    a_q[s] <= a_q[s-1];
`else
                    if (c_q[s-1][CTL_W-1]) begin
                        a_q[s] <= a_q[s-1];
                    end
`endif
                end
            end
        end

        assign bus.out_a[i*INPUT_W +: INPUT_W] = a_q[i];
        assign bus.out_valid[i]                = c_q[i][11];
        assign bus.out_propagate[i]            = c_q[i][10];
        assign bus.out_last[i]                 = c_q[i][9];
        assign bus.out_id[i*3 +: 3]            = c_q[i][8:6];
        assign bus.out_shift[i*5 +: 5]         = c_q[i][5:1];
        assign bus.out_dataflow[i]             = c_q[i][0];
    end
endmodule

// File: tb/tb_pe_row_skew_feeder.sv
// Testbench for pe_row_skew_feeder: directed commands; every accepted beat
// pushes per-lane expectations (data, control, arrival cycle) into lane
// queues, and a forked monitor pops and compares whenever a lane is valid.
module tb_pe_row_skew_feeder;
    localparam int INPUT_W = 8;
    localparam int DIM     = 4;
    localparam int LEN_W   = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    pe_row_skew_feeder_if #(.INPUT_W(INPUT_W), .DIM(DIM), .LEN_W(LEN_W)) bus();

    pe_row_skew_feeder #(.INPUT_W(INPUT_W), .DIM(DIM), .LEN_W(LEN_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [7:0] a;
        logic       prop;
        logic       last;
        logic [2:0] id;
        logic [4:0] shift;
        logic       df;
        int         cyc;
    } exp_t;

    exp_t       q0[$], q1[$], q2[$], q3[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         last_cyc = 0;
    logic       cur_df = 1'b0;
    logic [4:0] cur_shift = '0;
    logic [7:0] last_val [DIM];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int lane, input exp_t e);
        case (lane)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic flush_exp();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    task automatic monitor();
        exp_t e;
        logic got;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                for (int i = 0; i < DIM; i++) last_val[i] = '0;
            end else begin
                for (int i = 0; i < DIM; i++) begin
                    if (bus.out_valid[i]) begin
                        got = 1'b0;
                        e   = '0;
                        case (i)
                            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                            2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                            default: if (q3.size() > 0) begin e = q3.pop_front(); got = 1'b1; end
                        endcase
                        if (!got) begin
                            checks++;
                            failures++;
                            $display("FAIL lane%0d_unexpected: valid beat a=0x%0h, required no beat (cycle %0d)",
                                     i, bus.out_a[i*8 +: 8], cyc);
                        end else begin
                            chk($sformatf("lane%0d_fields", i),
                                {bus.out_a[i*8 +: 8], bus.out_propagate[i], bus.out_last[i],
                                 bus.out_id[i*3 +: 3], bus.out_shift[i*5 +: 5], bus.out_dataflow[i]},
                                {e.a, e.prop, e.last, e.id, e.shift, e.df});
                            chk($sformatf("lane%0d_arrival_cycle", i), cyc, e.cyc);
                        end
                        last_val[i] = bus.out_a[i*8 +: 8];
                    end else begin
`ifdef FEEDER_ZERO_BUBBLE_EN
                        chk($sformatf("lane%0d_bubble_zero", i), bus.out_a[i*8 +: 8], 8'h00);
`else
                        chk($sformatf("lane%0d_bubble_hold", i), bus.out_a[i*8 +: 8], last_val[i]);
`endif
                    end
                end
            end
        end
    endtask

    task automatic start_cmd(input logic df, input logic [4:0] sh,
                             input logic [7:0] len, input logic [7:0] nt);
        @(negedge clock);
        chk("cfg_ready_idle", bus.cfg_ready, 1'b1);
        chk("busy_idle", bus.busy, 1'b0);
        bus.cfg_valid     = 1'b1;
        bus.cfg_dataflow  = df;
        bus.cfg_shift     = sh;
        bus.cfg_tile_len  = len;
        bus.cfg_num_tiles = nt;
        bus.in_valid      = 1'b0;
        cur_df            = df;
        cur_shift         = sh;
    endtask

    task automatic send_beat(input logic [7:0] base, input logic prop, input logic [2:0] id,
                             input logic last, input logic cfg_too);
        exp_t e;
        @(negedge clock);
        bus.cfg_valid = cfg_too;
        if (cfg_too) begin
            bus.cfg_dataflow  = ~cur_df;
            bus.cfg_shift     = ~cur_shift;
            bus.cfg_tile_len  = 8'd7;
            bus.cfg_num_tiles = 8'd7;
            chk("cfg_ready_stream", bus.cfg_ready, 1'b0);
        end
        bus.in_valid = 1'b1;
        for (int i = 0; i < DIM; i++) bus.in_data[i*8 +: 8] = base + 8'(i);
        chk("in_ready_stream", bus.in_ready, 1'b1);
        last_cyc = cyc;
        for (int i = 0; i < DIM; i++) begin
            e.a     = base + 8'(i);
            e.prop  = prop;
            e.last  = last;
            e.id    = id;
            e.shift = cur_shift;
            e.df    = cur_df;
            e.cyc   = cyc + 1 + i;
            push_exp(i, e);
        end
    endtask

    task automatic idle_beat();
        @(negedge clock);
        bus.in_valid  = 1'b0;
        bus.cfg_valid = 1'b0;
        chk("in_ready_gap", bus.in_ready, 1'b1);
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        int seen;
        seen = -1;
        for (int k = 0; k < 40 && seen < 0; k++) begin
            @(negedge clock);
            bus.in_valid  = 1'b0;
            bus.cfg_valid = 1'b0;
            if (bus.done === 1'b1) seen = cyc;
        end
        chk({name, "_done_cycle"}, seen, exp_cyc);
        if (seen >= 0) chk({name, "_busy_at_done"}, bus.busy, 1'b1);
        @(negedge clock);
        chk({name, "_done_one_cycle"}, bus.done, 1'b0);
        chk({name, "_busy_after"}, bus.busy, 1'b0);
        chk({name, "_all_lanes_drained"}, q0.size() + q1.size() + q2.size() + q3.size(), 0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        flush_exp();
        @(negedge clock);
        #2 reset_n = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_out_a"}, bus.out_a, '0);
        chk({name, "_out_valid"}, bus.out_valid, '0);
        chk({name, "_out_ctl"}, {bus.out_propagate, bus.out_last, bus.out_id,
                                 bus.out_shift, bus.out_dataflow}, '0);
        chk({name, "_busy"}, bus.busy, 1'b0);
        chk({name, "_done"}, bus.done, 1'b0);
    endtask

    initial begin
        bus.cfg_valid     = 1'b0;
        bus.cfg_dataflow  = 1'b0;
        bus.cfg_shift     = '0;
        bus.cfg_tile_len  = '0;
        bus.cfg_num_tiles = '0;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        for (int i = 0; i < DIM; i++) last_val[i] = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        chk_outputs_zero("reset");
        chk("reset_cfg_ready", bus.cfg_ready, 1'b1);
        chk("reset_in_ready", bus.in_ready, 1'b0);

        // Test 1: one tile of 4 back-to-back beats, lane i = k+i
        start_cmd(1'b0, 5'd3, 8'd4, 8'd1);
        send_beat(8'd0,  1'b0, 3'd0, 1'b0, 1'b0);
        send_beat(8'd4,  1'b0, 3'd0, 1'b0, 1'b0);
        send_beat(8'd8,  1'b0, 3'd0, 1'b0, 1'b0);
        send_beat(8'd12, 1'b0, 3'd0, 1'b1, 1'b0);
        wait_done(last_cyc + DIM, "t1");

        // Test 2: from reset, tile_len=2, num_tiles=3
        apply_reset();
        start_cmd(1'b1, 5'd17, 8'd2, 8'd3);
        send_beat(8'h10, 1'b0, 3'd0, 1'b0, 1'b0);
        send_beat(8'h20, 1'b0, 3'd0, 1'b1, 1'b0);
        send_beat(8'h30, 1'b1, 3'd1, 1'b0, 1'b0);
        send_beat(8'h40, 1'b1, 3'd1, 1'b1, 1'b0);
        send_beat(8'h50, 1'b0, 3'd2, 1'b0, 1'b0);
        send_beat(8'h60, 1'b0, 3'd2, 1'b1, 1'b0);
        wait_done(last_cyc + DIM, "t2");

        // Test 3: state persists: first beat prop=1, id=3
        start_cmd(1'b0, 5'd31, 8'd1, 8'd2);
        send_beat(8'h70, 1'b1, 3'd3, 1'b1, 1'b0);
        send_beat(8'h80, 1'b0, 3'd4, 1'b1, 1'b0);
        wait_done(last_cyc + DIM, "t3");

        // Test 4: two-cycle input gap mid-tile
        start_cmd(1'b1, 5'd0, 8'd6, 8'd1);
        send_beat(8'h90, 1'b1, 3'd5, 1'b0, 1'b0);
        send_beat(8'hA0, 1'b1, 3'd5, 1'b0, 1'b0);
        idle_beat();
        idle_beat();
        send_beat(8'hB0, 1'b1, 3'd5, 1'b0, 1'b0);
        send_beat(8'hC0, 1'b1, 3'd5, 1'b0, 1'b0);
        send_beat(8'hD0, 1'b1, 3'd5, 1'b0, 1'b0);
        send_beat(8'hE0, 1'b1, 3'd5, 1'b1, 1'b0);
        wait_done(last_cyc + DIM, "t4");

        // Test 5: zero lengths mean one beat; cfg during STREAM ignored
        start_cmd(1'b1, 5'd9, 8'd0, 8'd0);
        send_beat(8'hF0, 1'b0, 3'd6, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            bus.cfg_valid = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = '1;
            chk("t5_in_ready_drain", bus.in_ready, 1'b0);
            chk("t5_cfg_ready_drain", bus.cfg_ready, 1'b0);
            chk("t5_busy_drain", bus.busy, 1'b1);
        end
        wait_done(last_cyc + DIM, "t5");

        // Test 6: reset during DRAIN (id wraps 7 -> 0 first)
        start_cmd(1'b0, 5'd2, 8'd1, 8'd2);
        send_beat(8'h11, 1'b1, 3'd7, 1'b1, 1'b0);
        send_beat(8'h22, 1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge clock);
        bus.in_valid = 1'b0;
        chk("t6_busy_in_drain", bus.busy, 1'b1);
        chk("t6_lane0_valid_before_reset", bus.out_valid[0], 1'b1);
        #2 reset_n = 1'b0;
        flush_exp();
        #1 chk_outputs_zero("t6_async");
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("t6_no_done", bus.done, 1'b0);
            chk("t6_idle", bus.busy, 1'b0);
        end
        // prop_q and id_q cleared by reset
        start_cmd(1'b1, 5'd1, 8'd1, 8'd1);
        send_beat(8'h33, 1'b0, 3'd0, 1'b1, 1'b0);
        wait_done(last_cyc + DIM, "t6_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_row_skew_feeder.md
Name: pe_row_skew_feeder

Overview:
- Upstream stage of a PE mesh row.
- Accepts one DIM-lane activation vector per handshake and produces the diagonal (skewed) stream the PE columns expect: lane i is delayed i cycles.
- Attaches per-lane control to each lane: valid, propagate, last, id, shift, dataflow.
- Sequences tiles for one command (propagate toggle and id increment per tile), then drains the skew pipeline.

Parameters:
- INPUT_W, 8, activation element width (matches PE in_a)
- DIM, 4, number of lanes / mesh rows fed; min 2
- LEN_W, 8, width of tile-length and tile-count config fields

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  command request
- cfg_ready  out  1  command accepted when high with cfg_valid
- cfg_dataflow  in  1  0=OS, 1=WS
- cfg_shift  in  5  output shift amount
- cfg_tile_len  in  LEN_W  beats per tile; 0 treated as 1
- cfg_num_tiles  in  LEN_W  tiles in command; 0 treated as 1
- in_valid  in  1  activation vector valid
- in_ready  out  1  feeder accepts vector
- in_data  in  DIM*INPUT_W  lane i at bits [i*INPUT_W +: INPUT_W]
- out_a  out  DIM*INPUT_W  skewed lanes to PE in_a
- out_valid  out  DIM  per-lane valid
- out_propagate  out  DIM  per-lane propagate
- out_last  out  DIM  per-lane last
- out_id  out  DIM*3  per-lane tile id
- out_shift  out  DIM*5  per-lane shift
- out_dataflow  out  DIM  per-lane dataflow
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on drain completion

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All skew registers and all outputs cleared to 0.
  - prop_q=0, id_q=0, counters=0.
- FSM IDLE:
  - cfg_ready=1, in_ready=0.
  - On cfg_valid: latch dataflow, shift, tile_len, num_tiles; clear beat_cnt and tile_cnt; go to STREAM.
- FSM STREAM:
  - cfg_ready=0, in_ready=1.
  - Accepted beat: lane-0 stage loads in_data lane 0, valid=1, propagate=prop_q, id=id_q, last=(beat_cnt==tile_len-1), plus latched shift and dataflow.
  - Remaining lanes' data enters delay chains of depth i.
  - No beat (in_valid=0): a bubble enters (valid=0, last=0); the skew pipeline still advances every cycle. There is no backpressure from the mesh.
  - On the last beat of a tile: beat_cnt resets to 0, prop_q toggles, id_q increments mod 8, tile_cnt increments.
  - On the last beat of the last tile: go to DRAIN with drain_cnt=DIM-1.
- FSM DRAIN:
  - in_ready=0, cfg_ready=0; bubbles are inserted.
  - drain_cnt decrements each cycle. At 0: go to IDLE and pulse done for 1 cycle (the cycle the last lane's last beat is on out_valid[DIM-1]).
- Latency:
  - Lane i output appears i+1 cycles after the accepting edge.
  - Lane 0 is registered; control fields of lane i travel with its data.
- prop_q and id_q are not reset between commands. Only reset_n clears them, so the PE last_s tracking stays consistent.
- cfg_valid during STREAM/DRAIN is ignored (cfg_ready=0).
- in_valid in IDLE is not accepted.
- Mid-operation reset: everything clears immediately; no partial done pulse.
- busy=1 in STREAM and DRAIN.

Optional Feature:
- FEEDER_ZERO_BUBBLE_EN defined: bubble slots drive out_a lane value 0.
- Not defined: data registers hold their previous value on bubbles (data enable = valid, lower toggle power). Control fields always update.
- Either way, out_valid=0 on bubbles.

Test Plan:
1. Reset then cfg (dataflow=0, shift=3, tile_len=4, num_tiles=1), then 4 back-to-back beats with lane values {k,k+1,k+2,k+3} for k=0,4,8,12:
   - out_a lane 2 shows 2,6,10,14 starting 3 cycles after first accept.
   - out_last[2]=1 with value 14.
   - done pulses 4 cycles after the final accept; busy falls on the following cycle.
2. tile_len=2, num_tiles=3 from reset:
   - lane 0 propagate sequence 0,0,1,1,0,0.
   - id sequence 0,0,1,1,2,2.
   - last on beats 1, 3 and 5.
3. Second command after test 2:
   - first beat carries propagate=1, id=3 (state persists across commands).
4. in_valid deasserted for 2 cycles mid-tile:
   - each lane shows a 2-cycle out_valid gap at its own skewed position.
   - With FEEDER_ZERO_BUBBLE_EN, out_a=0 in the gap; without, out_a holds.
5. cfg_tile_len=0, cfg_num_tiles=0:
   - exactly one beat accepted, out_last=1 on it, then DRAIN and done.
   - cfg_valid asserted during STREAM is ignored (cfg_ready=0).
6. reset_n asserted low during DRAIN:
   - all outputs 0 asynchronously, no done pulse, returns to IDLE.
   - prop_q=0 and id_q=0 afterwards.
